// File: rtl/smg_pkg.sv
// ----------------------------------------------------------------------------
// smg_pkg : shared types and defaults for the seven-segment display arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package smg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW   = 2'd1,
    SWITCH = 2'd2
  } smg_state_e;

  localparam int SMG_N_SRC_DEFAULT = 4;
  localparam int SMG_DWELL_DEFAULT = 50_000_000;

  // Width matches the display interface's number input.
  typedef logic [15:0] smg_num_t;

endpackage

`default_nettype wire

// File: rtl/smg_rr_pick.sv
// ----------------------------------------------------------------------------
// smg_rr_pick : combinational round-robin picker, search starts after Last_Id
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module smg_rr_pick #(
  parameter  int N_SRC = 4,
  localparam int SRC_W = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] Req_Sig,
  input  logic [SRC_W-1:0] Last_Id,
  output logic [SRC_W-1:0] Pick,
  output logic             Found
);

  localparam logic [SRC_W:0] N_EXT = (SRC_W+1)'(N_SRC);

  logic [SRC_W:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    Pick  = '0;
    Found = 1'b0;
    idx   = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = {1'b0, Last_Id} + (SRC_W+1)'(k);
      if (idx >= N_EXT) begin
        idx = idx - N_EXT;
      end
      if (Req_Sig[idx[SRC_W-1:0]]) begin
        Pick  = idx[SRC_W-1:0];
        Found = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/smg_display_arbiter.sv
// ----------------------------------------------------------------------------
// smg_display_arbiter : time-slices the 4-digit display among debug sources
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module smg_display_arbiter
  import smg_pkg::*;
#(
  parameter  int N_SRC = SMG_N_SRC_DEFAULT,
  parameter  int DWELL = SMG_DWELL_DEFAULT,
  localparam int SRC_W = $clog2(N_SRC),
  localparam int CNT_W = $clog2(DWELL)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_SRC-1:0]     Req_Sig,
  input  logic [16*N_SRC-1:0]  Value_Bus,
  input  logic                 Pin_En,
  input  logic                 Next_Btn,
  output smg_num_t             Number_Sig,
  output logic [N_SRC-1:0]     Grant,
  output logic [SRC_W-1:0]     Src_Id,
  output logic                 Valid,
  output logic [N_SRC-1:0]     Ack
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DWELL - 1);
  localparam logic [N_SRC-1:0] ONE_HOT0 = N_SRC'(1);
  localparam logic [SRC_W-1:0] LAST_RST = SRC_W'(N_SRC - 1);

  smg_state_e        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [SRC_W-1:0]  last_id, last_id_nxt;
  logic              next_d;

  smg_num_t          num_nxt;
  logic [N_SRC-1:0]  grant_nxt;
  logic [SRC_W-1:0]  src_nxt;
  logic              valid_nxt;
  logic [N_SRC-1:0]  ack_nxt;

  logic [SRC_W-1:0]  pick;
  logic              found;
  logic              expire;
  logic              next_edge;
  logic              drop;
  logic              slot_end;

  smg_num_t          slices [N_SRC];

  for (genvar i = 0; i < N_SRC; i++) begin : g_slice
    assign slices[i] = Value_Bus[16*i +: 16];
  end

  smg_rr_pick #(
    .N_SRC (N_SRC)
  ) u_pick (
    .Req_Sig (Req_Sig),
    .Last_Id (last_id),
    .Pick    (pick),
    .Found   (found)
  );

  assign expire    = (cnt == CNT_MAX) && !Pin_En;
  assign next_edge = Next_Btn && !next_d;
  assign drop      = !Req_Sig[Src_Id];
  assign slot_end  = expire || next_edge || drop;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      last_id    <= LAST_RST;
      next_d     <= 1'b0;
      Number_Sig <= '0;
      Grant      <= '0;
      Src_Id     <= '0;
      Valid      <= 1'b0;
      Ack        <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_id    <= last_id_nxt;
      next_d     <= Next_Btn;
      Number_Sig <= num_nxt;
      Grant      <= grant_nxt;
      Src_Id     <= src_nxt;
      Valid      <= valid_nxt;
      Ack        <= ack_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, SWITCH: state_nxt = found ? SHOW : IDLE;
      SHOW:         state_nxt = slot_end ? SWITCH : SHOW;
      default:      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt     = cnt;
    last_id_nxt = last_id;
    num_nxt     = Number_Sig;
    grant_nxt   = '0;
    src_nxt     = Src_Id;
    valid_nxt   = 1'b0;
    ack_nxt     = '0;
    unique case (state)
      IDLE, SWITCH: begin
        if (found) begin
          grant_nxt   = ONE_HOT0 << pick;
          valid_nxt   = 1'b1;
          src_nxt     = pick;
          last_id_nxt = pick;
          cnt_nxt     = '0;
          num_nxt     = slices[pick];
        end else begin
          num_nxt = '0;
        end
      end
      SHOW: begin
        num_nxt = slices[Src_Id];
        cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        if (slot_end) begin
          // A dropped request never earns an acknowledge, even alongside expiry.
          if (!drop) begin
            ack_nxt = ONE_HOT0 << Src_Id;
          end
        end else begin
          grant_nxt = Grant;
          valid_nxt = 1'b1;
        end
      end
      default: begin
        num_nxt = '0;
      end
    endcase
  end

endmodule

`default_nettype wire
